// File: rtl/ixc_pkg.sv
// Shared definitions for the ixc datapath blocks: word width, counter width and skid FSM states.
package ixc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ixc_skid_32.sv
// Two-entry skid buffer feeding the 32-bit assign stage; one cycle latency when empty, full rate.
// in_ready/out_valid come straight from flops, so ready and valid never form combinational paths.
module ixc_skid_32
  import ixc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RST_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  xfer_cnt
);

  skid_state_e       state_q;
  logic [WORD_W-1:0] main_q;
  logic [WORD_W-1:0] skid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic accept;
  logic xfer;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  // Handshake flags are updated alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= RST_DATA;
      skid_q      <= RST_DATA;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q     <= ST_BUSY;
            main_q      <= in_data;
            out_valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && xfer) begin
            main_q <= in_data;
          end else if (accept) begin
            state_q    <= ST_FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end else if (xfer) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_q    <= ST_BUSY;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign xfer_cnt  = cnt_q;

endmodule
